// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared Q4.12 constants and FSM state encoding for the LeNet-5 datapath
package lenet_pkg;

  localparam int FRAC_BITS = 12;
  localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ACCUM = 3'b010,
    HOLD  = 3'b100
  } state_t;

endpackage

// File: rtl/sat_relu.sv
// rtl/sat_relu.sv - clamp a wide signed Q.12 accumulator to Q4.12 with optional ReLU
module sat_relu
  import lenet_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [IN_W-1:0]  acc_in,
  output logic signed [OUT_W-1:0] result_out
);

  // Bounds are the Q4.12 limits sign-extended to the accumulator width
  localparam logic signed [IN_W-1:0] HI = IN_W'(Q_MAX);
  localparam logic signed [IN_W-1:0] LO = IN_W'(Q_MIN);

  always_comb begin
    if (RELU_EN && (acc_in < 0)) begin
      result_out = '0;
    end else if (acc_in > HI) begin
      result_out = HI[OUT_W-1:0];
    end else if (acc_in < LO) begin
      result_out = LO[OUT_W-1:0];
    end else begin
      result_out = acc_in[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// rtl/conv_accumulator.sv - sums KERNEL_SIZE Q4.12 products plus bias per window, saturates, hands off
module conv_accumulator
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int KERNEL_SIZE = 25,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] product_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         busy
);

  localparam logic [7:0] LAST_IDX = 8'(KERNEL_SIZE - 1);

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [7:0]                    count_q, count_d;
  logic signed [DATA_WIDTH-1:0]  result_q, result_d;
  logic signed [DATA_WIDTH-1:0]  sat_out;
  logic                          accept;

  // Gated by rst so nothing is advertised while reset is held
  assign in_ready  = !rst && ((state_q == IDLE) || (state_q == ACCUM));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == ACCUM);
  assign result    = result_q;

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d   = ACC_WIDTH'(product_in) + ACC_WIDTH'(bias_in);
        count_d = 8'd1;
      end
      ACCUM: if (accept) begin
        acc_d   = acc_q + ACC_WIDTH'(product_in);
        count_d = count_q + 8'd1;
      end
      HOLD: if (out_ready) begin
        acc_d   = '0;
        count_d = '0;
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // The saturator sees the next accumulator value so the result is captured on HOLD entry
  sat_relu #(
    .IN_W    (ACC_WIDTH),
    .OUT_W   (DATA_WIDTH),
    .RELU_EN (RELU_EN)
  ) u_sat_relu (
    .acc_in     (acc_d),
    .result_out (sat_out)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (accept) begin
        if (KERNEL_SIZE == 1) begin
          state_d  = HOLD;
          result_d = sat_out;
        end else begin
          state_d = ACCUM;
        end
      end
      ACCUM: if (accept && (count_q == LAST_IDX)) begin
        state_d  = HOLD;
        result_d = sat_out;
      end
      HOLD: if (out_ready) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

endmodule
